// File: rtl/wr_ptr_ctrl.sv
// Write-side pointer and flag controller for a single-clock stream FIFO.
// Drives the RAM write strobe/address and tracks full, almost-full, level and overflow.
module wr_ptr_ctrl #(
  parameter int ALEN         = 8,
  parameter int AFULL_THRESH = 2**ALEN - 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_tvalid,
  output logic            o_tready,
  output logic            o_ram_wen,
  output logic [ALEN-1:0] o_waddr,
  output logic [ALEN:0]   o_wptr,
  input  logic [ALEN:0]   i_rptr,
  output logic            o_wfull,
  output logic            o_wafull,
  output logic [ALEN:0]   o_wlevel,
  output logic            o_overflow,
  input  logic            i_ovf_clr
);

  localparam logic [ALEN:0] AFULL_LVL = (ALEN+1)'(AFULL_THRESH);
  localparam logic [ALEN:0] PTR_INC   = (ALEN+1)'(1);

  logic [ALEN:0] wptr_q, wptr_d;
  logic [ALEN:0] wlevel_q, wlevel_d;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic          ovf_q, ovf_d;
  logic          accept;

  assign accept = i_tvalid & ~wfull_q;

  always_comb begin
    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
    wptr_d   = wptr_q;
    ovf_d    = ovf_q;
    if (accept) wptr_d = wptr_q + PTR_INC;

    // Flags compare against the read pointer as it stands now, so they lag reads by a cycle
    // and can only ever over-report occupancy, never under-report it.
    wlevel_d = wptr_d - i_rptr;
    wfull_d  = (wptr_d[ALEN] != i_rptr[ALEN]) && (wptr_d[ALEN-1:0] == i_rptr[ALEN-1:0]);
    wafull_d = (wlevel_d >= AFULL_LVL);

    // A beat offered while full wins over a simultaneous clear.
    if (i_ovf_clr)           ovf_d = 1'b0;
    if (i_tvalid && wfull_q) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    if (!rstn) begin
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_tready   = ~wfull_q;
  assign o_ram_wen  = accept;
  assign o_waddr    = wptr_q[ALEN-1:0];
  assign o_wptr     = wptr_q;
  assign o_wfull    = wfull_q;
  assign o_wafull   = wafull_q;
  assign o_wlevel   = wlevel_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Self-checking bench for wr_ptr_ctrl (depth 8, almost-full at 6).
// Reference model counts total beats written and read as plain integers.
module tb_wr_ptr_ctrl;

  localparam int ALEN  = 3;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_tvalid = 1'b0;
  logic       i_ovf_clr = 1'b0;
  logic [3:0] i_rptr = '0;
  logic       o_tready, o_ram_wen, o_wfull, o_wafull, o_overflow;
  logic [2:0] o_waddr;
  logic [3:0] o_wptr, o_wlevel;

  wr_ptr_ctrl #(.ALEN(ALEN), .AFULL_THRESH(AFT)) dut (
    .clk(clk), .rstn(rstn), .i_tvalid(i_tvalid), .o_tready(o_tready),
    .o_ram_wen(o_ram_wen), .o_waddr(o_waddr), .o_wptr(o_wptr), .i_rptr(i_rptr),
    .o_wfull(o_wfull), .o_wafull(o_wafull), .o_wlevel(o_wlevel),
    .o_overflow(o_overflow), .i_ovf_clr(i_ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: totals of beats accepted and beats consumed.
  int m_wr = 0;
  int m_rd = 0;
  int m_level = 0;
  bit m_full = 0, m_afull = 0, m_ovf = 0;

  // Pre-edge observations and model expectations captured by tick().
  logic       obs_wen, obs_tready;
  logic [2:0] obs_waddr;
  bit         exp_wen, exp_tready;
  logic [2:0] exp_waddr;

  function automatic logic [10:0] act_state();
    return {o_wptr, o_wlevel, o_wfull, o_wafull, o_overflow};
  endfunction

  function automatic logic [10:0] exp_state();
    return {4'(m_wr), 4'(m_level), m_full, m_afull, m_ovf};
  endfunction

  task automatic set_rd(input int v);
    m_rd   = v;
    i_rptr = 4'(v);
  endtask

  // One clock: observe combinational outputs mid-cycle, cross the edge, advance the model.
  task automatic tick();
    bit acc, was_full;
    #1;
    obs_wen    = o_ram_wen;
    obs_waddr  = o_waddr;
    obs_tready = o_tready;
    exp_wen    = i_tvalid && !m_full;
    exp_waddr  = 3'(m_wr % DEPTH);
    exp_tready = !m_full;
    acc        = exp_wen;
    was_full   = m_full;
    @(posedge clk);
    if (!rstn) begin
      m_wr = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
    end else begin
      if (acc) m_wr++;
      m_level = m_wr - m_rd;
      m_full  = (m_level == DEPTH);
      m_afull = (m_level >= AFT);
      if (i_tvalid && was_full) m_ovf = 1;
      else if (i_ovf_clr)       m_ovf = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; i_tvalid = 1'b0; i_ovf_clr = 1'b0;
    set_rd(0);
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_tvalid = 1'b1; i_ovf_clr = 1'b0;
    set_rd(0);
    repeat (3) tick();
    n_checks++;
    if (act_state() !== 11'd0) begin
      n_errors++; $display("FAIL reset_state: got %h want %h", act_state(), 11'd0);
    end
    n_checks++;
    if (o_tready !== 1'b1 || o_waddr !== 3'd0) begin
      n_errors++; $display("FAIL reset_ready_addr: got tready=%b waddr=%0d want 1/0", o_tready, o_waddr);
    end
    rstn = 1'b1;
    tick();
    n_checks++;
    if (obs_wen !== 1'b1 || obs_waddr !== 3'd0) begin
      n_errors++; $display("FAIL reset_first_beat: got wen=%b addr=%0d want 1/0", obs_wen, obs_waddr);
    end
    n_checks++;
    if (o_wptr !== 4'd1) begin
      n_errors++; $display("FAIL reset_wptr_after_beat: got %0d want 1", o_wptr);
    end
  endtask

  task automatic test_fill();
    int pulses = 0;
    do_reset();
    i_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (obs_wen !== exp_wen || (obs_wen && obs_waddr !== 3'(pulses))) begin
        n_errors++;
        $display("FAIL fill_wen[%0d]: got wen=%b addr=%0d want wen=%b addr=%0d", i, obs_wen, obs_waddr, exp_wen, pulses);
      end
      if (obs_wen === 1'b1) pulses++;
      n_checks++;
      if (act_state() !== exp_state()) begin
        n_errors++; $display("FAIL fill_state[%0d]: got %h want %h", i, act_state(), exp_state());
      end
    end
    n_checks++;
    if (pulses != DEPTH) begin
      n_errors++; $display("FAIL fill_pulses: got %0d want %0d", pulses, DEPTH);
    end
    n_checks++;
    if (o_wptr !== 4'd8 || o_wlevel !== 4'd8 || o_tready !== 1'b0 || o_overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL fill_final: got wptr=%0d lvl=%0d rdy=%b ovf=%b want 8/8/0/1", o_wptr, o_wlevel, o_tready, o_overflow);
    end
  endtask

  task automatic test_drain_release();
    set_rd(1);
    tick();
    n_checks++;
    if (o_wfull !== 1'b0 || o_tready !== 1'b1 || act_state() !== exp_state()) begin
      n_errors++; $display("FAIL drain_release: got full=%b state=%h want full=0 state=%h", o_wfull, act_state(), exp_state());
    end
    tick();
    n_checks++;
    if (obs_wen !== 1'b1 || obs_waddr !== 3'd0) begin
      n_errors++; $display("FAIL drain_beat: got wen=%b addr=%0d want 1/0", obs_wen, obs_waddr);
    end
    n_checks++;
    if (o_wptr !== 4'd9 || o_wfull !== 1'b1 || act_state() !== exp_state()) begin
      n_errors++; $display("FAIL drain_refull: got wptr=%0d full=%b want 9/1", o_wptr, o_wfull);
    end
  endtask

  task automatic test_wrap();
    int hist[$];
    bit saw_wrap = 0;
    logic [3:0] prev = '0;
    do_reset();
    i_tvalid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      n_checks++;
      if (obs_wen !== 1'b1 || obs_waddr !== 3'(k % DEPTH)) begin
        n_errors++; $display("FAIL wrap_addr[%0d]: got wen=%b addr=%0d want 1/%0d", k, obs_wen, obs_waddr, k % DEPTH);
      end
      n_checks++;
      if (o_wfull !== 1'b0 || o_wlevel > 4'd3 || act_state() !== exp_state()) begin
        n_errors++; $display("FAIL wrap_state[%0d]: got %h want %h", k, act_state(), exp_state());
      end
      if (prev == 4'd15 && o_wptr == 4'd0) saw_wrap = 1;
      prev = o_wptr;
      hist.push_back(m_wr);
      if (hist.size() > 2) set_rd(hist.pop_front());
    end
    n_checks++;
    if (!saw_wrap || o_wptr !== 4'd8) begin
      n_errors++; $display("FAIL wrap_seen: got wrap=%0d wptr=%0d want 1/8", saw_wrap, o_wptr);
    end
  endtask

  task automatic test_ovf_clear();
    do_reset();
    i_tvalid = 1'b1;
    repeat (9) tick();
    n_checks++;
    if (o_overflow !== 1'b1) begin
      n_errors++; $display("FAIL ovf_set: got %b want 1", o_overflow);
    end
    i_tvalid = 1'b0; i_ovf_clr = 1'b1;
    tick();
    n_checks++;
    if (o_overflow !== 1'b0 || act_state() !== exp_state()) begin
      n_errors++; $display("FAIL ovf_clear: got %b want 0", o_overflow);
    end
    i_tvalid = 1'b1; i_ovf_clr = 1'b0;
    tick();
    i_ovf_clr = 1'b1;
    tick();
    n_checks++;
    if (o_overflow !== 1'b1 || act_state() !== exp_state()) begin
      n_errors++; $display("FAIL ovf_set_wins: got %b want 1", o_overflow);
    end
    i_tvalid = 1'b0;
    tick();
    n_checks++;
    if (o_overflow !== 1'b0) begin
      n_errors++; $display("FAIL ovf_clear2: got %b want 0", o_overflow);
    end
    i_ovf_clr = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    i_tvalid = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (o_wlevel !== 4'd5 || o_wafull !== 1'b0) begin
      n_errors++; $display("FAIL mid_level: got lvl=%0d afull=%b want 5/0", o_wlevel, o_wafull);
    end
    rstn = 1'b0;
    set_rd(0);
    tick();
    n_checks++;
    if (act_state() !== 11'd0 || o_tready !== 1'b1 || o_waddr !== 3'd0) begin
      n_errors++; $display("FAIL mid_reset_state: got %h rdy=%b want 0/1", act_state(), o_tready);
    end
    rstn = 1'b1;
    tick();
    n_checks++;
    if (obs_wen !== 1'b1 || obs_waddr !== 3'd0 || o_wptr !== 4'd1) begin
      n_errors++; $display("FAIL mid_reset_beat: got wen=%b addr=%0d wptr=%0d want 1/0/1", obs_wen, obs_waddr, o_wptr);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      i_tvalid  = ($urandom_range(0, 3) != 0);
      i_ovf_clr = ($urandom_range(0, 15) == 0);
      if (m_rd < m_wr && $urandom_range(0, 3) < ((i < 200) ? 1 : 3)) set_rd(m_rd + 1);
      tick();
      n_checks++;
      if (obs_wen !== exp_wen || obs_tready !== exp_tready || (exp_wen && obs_waddr !== exp_waddr)) begin
        n_errors++;
        $display("FAIL rand_comb[%0d]: got wen=%b rdy=%b addr=%0d want %b/%b/%0d", i, obs_wen, obs_tready, obs_waddr, exp_wen, exp_tready, exp_waddr);
      end
      n_checks++;
      if (act_state() !== exp_state()) begin
        n_errors++; $display("FAIL rand_state[%0d]: got %h want %h", i, act_state(), exp_state());
      end
    end
    i_tvalid = 1'b0; i_ovf_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_release();
    test_wrap();
    test_ovf_clear();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
